dtm_dmi_jtag: RTL and testbench



---
 rtl/dtm_dmi_jtag.sv | 179 +++++++++++++++++
 tb/tb_dtm_dmi_jtag.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtm_dmi_jtag.sv
// JTAG-side DTMCS / DMI data registers of the debug transport module.
// Turns completed DMI scans into valid/ready requests toward the debug module.
module dtm_dmi_jtag #(
  parameter int unsigned AbitsW     = 7,
  parameter logic [2:0]  IdleCycles = 3'd1
) (
  input  logic              tck_i,
  input  logic              trst_i,
  input  logic              dmi_clear_i,
  input  logic              capture_i,
  input  logic              shift_i,
  input  logic              update_i,
  input  logic              tdi_i,
  input  logic              dtmcs_select_i,
  output logic              dtmcs_tdo_o,
  input  logic              dmi_select_i,
  output logic              dmi_tdo_o,
  output logic              dmi_req_valid_o,
  input  logic              dmi_req_ready_i,
  output logic [AbitsW-1:0] dmi_req_addr_o,
  output logic [31:0]       dmi_req_data_o,
  output logic [1:0]        dmi_req_op_o,
  input  logic              dmi_resp_valid_i,
  output logic              dmi_resp_ready_o,
  input  logic [31:0]       dmi_resp_data_i,
  input  logic [1:0]        dmi_resp_op_i
);

  localparam int unsigned DmiW = AbitsW + 34;

  localparam logic [1:0] ErrNone   = 2'd0;
  localparam logic [1:0] ErrFailed = 2'd2;
  localparam logic [1:0] ErrBusy   = 2'd3;
  localparam logic [1:0] OpRead    = 2'd1;
  localparam logic [1:0] OpWrite   = 2'd2;

  typedef enum logic [2:0] {
    Idle,
    Read,
    WaitRead,
    Write,
    WaitWrite
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        error_q, error_d;
  logic [AbitsW-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        op_q, op_d;
  logic [31:0]       dtmcs_sr_q, dtmcs_sr_d;
  logic [DmiW-1:0]   dmi_sr_q, dmi_sr_d;
  logic              req_valid_q, resp_ready_q;

  logic [31:0]       dtmcs_value;
  logic [AbitsW-1:0] sr_addr;
  logic [31:0]       sr_data;
  logic [1:0]        sr_op;
  logic [1:0]        capture_op;

  assign dtmcs_value = {14'd0, 1'b0, 1'b0, 1'b0, IdleCycles, error_q, 6'(AbitsW), 4'd1};
  assign sr_addr     = dmi_sr_q[DmiW-1 -: AbitsW];
  assign sr_data     = dmi_sr_q[33:2];
  assign sr_op       = dmi_sr_q[1:0];

  // Next-state: DM handshake first, then TAP strobes (hardreset must win)
  always_comb begin
    state_d    = state_q;
    error_d    = error_q;
    addr_d     = addr_q;
    data_d     = data_q;
    op_d       = op_q;
    dtmcs_sr_d = dtmcs_sr_q;
    dmi_sr_d   = dmi_sr_q;
    capture_op = ErrNone;

    case (state_q)
      Read:  if (dmi_req_ready_i) state_d = WaitRead;
      Write: if (dmi_req_ready_i) state_d = WaitWrite;
      WaitRead, WaitWrite: begin
        if (dmi_resp_valid_i) begin
          state_d = Idle;
          if (dmi_resp_op_i != 2'd0) begin
            if (error_q == ErrNone) error_d = ErrFailed;
          end else if (state_q == WaitRead) begin
            data_d = dmi_resp_data_i;
          end
        end
      end
      default: ;
    endcase

    if (dtmcs_select_i) begin
      if (capture_i) begin
        dtmcs_sr_d = dtmcs_value;
      end else if (shift_i) begin
        dtmcs_sr_d = {tdi_i, dtmcs_sr_q[31:1]};
      end else if (update_i) begin
        if (dtmcs_sr_q[17]) begin
          error_d = ErrNone;
          state_d = Idle;
        end else if (dtmcs_sr_q[16]) begin
          error_d = ErrNone;
        end
      end
    end

    if (dmi_select_i) begin
      if (capture_i) begin
        if (error_q != ErrNone) begin
          capture_op = error_q;
        end else if (state_q != Idle) begin
          capture_op = ErrBusy;
          error_d    = ErrBusy;
        end
        dmi_sr_d = {addr_q, data_q, capture_op};
      end else if (shift_i) begin
        dmi_sr_d = {tdi_i, dmi_sr_q[DmiW-1:1]};
      end else if (update_i && (error_q == ErrNone)) begin
        if (state_q != Idle) begin
          error_d = ErrBusy;
        end else begin
          addr_d = sr_addr;
          if (sr_op == OpRead) begin
            state_d = Read;
            op_d    = OpRead;
          end else if (sr_op == OpWrite) begin
            data_d  = sr_data;
            state_d = Write;
            op_d    = OpWrite;
          end
        end
      end
    end
  end

  // State and registered request/response handshake outputs
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      state_q      <= Idle;
      error_q      <= ErrNone;
      addr_q       <= '0;
      data_q       <= '0;
      op_q         <= '0;
      dtmcs_sr_q   <= '0;
      dmi_sr_q     <= '0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b1;
    end else if (dmi_clear_i) begin
      state_q      <= Idle;
      error_q      <= ErrNone;
      addr_q       <= '0;
      data_q       <= '0;
      op_q         <= '0;
      dtmcs_sr_q   <= '0;
      dmi_sr_q     <= '0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      error_q      <= error_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      op_q         <= op_d;
      dtmcs_sr_q   <= dtmcs_sr_d;
      dmi_sr_q     <= dmi_sr_d;
      req_valid_q  <= (state_d == Read) || (state_d == Write);
      resp_ready_q <= !((state_d == Read) || (state_d == Write));
    end
  end

  assign dtmcs_tdo_o      = dtmcs_sr_q[0];
  assign dmi_tdo_o        = dmi_sr_q[0];
  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_resp_ready_o = resp_ready_q;
  assign dmi_req_addr_o   = addr_q;
  assign dmi_req_data_o   = data_q;
  assign dmi_req_op_o     = op_q;

endmodule

// File: tb/tb_dtm_dmi_jtag.sv
// Scoreboard bench for dtm_dmi_jtag: scan/request expectations come from a
// transaction-level model of the DTM and are checked by an independent monitor.
module tb_dtm_dmi_jtag;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = AW + 34;

  logic          tck = 1'b0;
  logic          trst = 1'b1;
  logic          dmi_clear = 1'b0;
  logic          capture = 1'b0, shift = 1'b0, update = 1'b0, tdi = 1'b0;
  logic          dtmcs_sel = 1'b0, dmi_sel = 1'b0;
  logic          dtmcs_tdo, dmi_tdo;
  logic          req_valid, req_ready = 1'b0;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic [1:0]    req_op;
  logic          resp_valid = 1'b0, resp_ready;
  logic [31:0]   resp_data = '0;
  logic [1:0]    resp_op = '0;

  dtm_dmi_jtag #(.AbitsW(AW), .IdleCycles(3'd1)) dut (
    .tck_i(tck), .trst_i(trst), .dmi_clear_i(dmi_clear),
    .capture_i(capture), .shift_i(shift), .update_i(update), .tdi_i(tdi),
    .dtmcs_select_i(dtmcs_sel), .dtmcs_tdo_o(dtmcs_tdo),
    .dmi_select_i(dmi_sel), .dmi_tdo_o(dmi_tdo),
    .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready),
    .dmi_req_addr_o(req_addr), .dmi_req_data_o(req_data), .dmi_req_op_o(req_op),
    .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(resp_ready),
    .dmi_resp_data_i(resp_data), .dmi_resp_op_i(resp_op)
  );

  always #5 tck = ~tck;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [1:0]    op;
  } req_t;

  req_t        exp_req_q[$];
  logic [63:0] exp_scan_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  // Transaction-level model of the DTM
  logic [1:0]    m_err = 2'd0;
  bit            m_busy = 1'b0;
  bit            m_pending = 1'b0;
  bit            m_read = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_err = 2'd0; m_busy = 1'b0; m_pending = 1'b0; m_read = 1'b0;
    m_addr = '0; m_data = '0;
    exp_req_q.delete();
    exp_scan_q.delete();
  endtask

  // Monitor: collects TDO streams and request handshakes, pops expectations
  logic [63:0] acc;
  int          cnt = 0;
  bit          cap_seen = 1'b0;
  initial begin
    forever begin
      @(negedge tck);
      if (trst) begin
        cap_seen = 1'b0;
      end else begin
        if (dmi_sel || dtmcs_sel) begin
          if (capture) begin
            acc = '0; cnt = 0; cap_seen = 1'b1;
          end else if (shift) begin
            if (cnt < 64) acc[cnt] = dmi_sel ? dmi_tdo : dtmcs_tdo;
            cnt++;
          end else if (update && cap_seen) begin
            cap_seen = 1'b0;
            if (exp_scan_q.size() == 0) begin
              n_checks++;
              $display("FAIL scan_unexpected: got %0h, required no scan", acc);
            end else begin
              check("scan_out", acc, exp_scan_q.pop_front());
            end
          end
        end
        if (req_valid && req_ready) begin
          if (exp_req_q.size() == 0) begin
            n_checks++;
            $display("FAIL req_unexpected: got addr %0h data %0h op %0h, required none",
                     req_addr, req_data, req_op);
          end else begin
            check("req_fields", 64'({req_addr, req_data, req_op}), 64'(exp_req_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic dmi_scan(input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [1:0] o, input bit do_cap);
    logic [DW-1:0] v;
    logic [1:0]    cop;
    v = {a, d, o};
    @(posedge tck); #1;
    dmi_sel = 1'b1;
    if (do_cap) begin
      cop = (m_err != 2'd0) ? m_err : (m_busy ? 2'd3 : 2'd0);
      if (m_err == 2'd0 && m_busy) m_err = 2'd3;
      exp_scan_q.push_back(64'({m_addr, m_data, cop}));
      capture = 1'b1;
      @(posedge tck); #1;
      capture = 1'b0;
    end
    for (int i = 0; i < DW; i++) begin
      shift = 1'b1; tdi = v[i];
      @(posedge tck); #1;
    end
    shift = 1'b0; update = 1'b1;
    @(posedge tck); #1;
    update = 1'b0; dmi_sel = 1'b0;
    if (m_err == 2'd0) begin
      if (m_busy) begin
        m_err = 2'd3;
      end else begin
        m_addr = a;
        if (o == 2'd2) m_data = d;
        if (o == 2'd1 || o == 2'd2) begin
          m_busy = 1'b1; m_pending = 1'b1; m_read = (o == 2'd1);
          exp_req_q.push_back('{addr: a, data: m_data, op: o});
        end
      end
    end
    @(negedge tck);
    check("req_valid_after_update", 64'(req_valid), 64'(m_pending));
  endtask

  task automatic dtmcs_scan(input logic [31:0] v);
    @(posedge tck); #1;
    dtmcs_sel = 1'b1; capture = 1'b1;
    exp_scan_q.push_back(64'(32'h0000_1071 | (32'(m_err) << 10)));
    @(posedge tck); #1;
    capture = 1'b0;
    for (int i = 0; i < 32; i++) begin
      shift = 1'b1; tdi = v[i];
      @(posedge tck); #1;
    end
    shift = 1'b0; update = 1'b1;
    @(posedge tck); #1;
    update = 1'b0; dtmcs_sel = 1'b0;
    if (v[17]) begin
      m_err = 2'd0; m_busy = 1'b0; m_pending = 1'b0;
      exp_req_q.delete();
    end else if (v[16]) begin
      m_err = 2'd0;
    end
    @(negedge tck);
    check("req_valid_after_dtmcs", 64'(req_valid), 64'(m_pending));
  endtask

  task automatic dm_handshake(input int dly);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < dly; i++) begin
      @(negedge tck);
      check("req_hold_valid", 64'(req_valid), 64'd1);
      if (exp_req_q.size() > 0)
        check("req_hold_fields", 64'({req_addr, req_data, req_op}), 64'(exp_req_q[0]));
    end
    @(posedge tck); #1;
    req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge tck);
      if (req_valid) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL req_timeout: got no valid in 20 cycles, required a request");
    end
    @(posedge tck); #1;
    req_ready = 1'b0;
    m_pending = 1'b0;
  endtask

  task automatic dm_respond(input logic [31:0] d, input logic [1:0] o, input int dly);
    bit seen;
    seen = 1'b0;
    repeat (dly) @(posedge tck);
    @(posedge tck); #1;
    resp_valid = 1'b1; resp_data = d; resp_op = o;
    for (int i = 0; i < 20; i++) begin
      @(negedge tck);
      if (resp_ready) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL resp_timeout: got no resp_ready in 20 cycles, required acceptance");
    end
    @(posedge tck); #1;
    resp_valid = 1'b0;
    if (o != 2'd0) begin
      if (m_err == 2'd0) m_err = 2'd2;
    end else if (m_read) begin
      m_data = d;
    end
    m_busy = 1'b0;
  endtask

  task automatic check_no_req(input int n);
    @(posedge tck); #1;
    req_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge tck);
      check("no_req_valid", 64'(req_valid), 64'd0);
    end
    @(posedge tck); #1;
    req_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(req_valid), 64'd0);
    check({tag, "_resp_ready"}, 64'(resp_ready), 64'd1);
    check({tag, "_addr_data_op"}, 64'({req_addr, req_data, req_op}), 64'd0);
    check({tag, "_tdo"}, 64'({dtmcs_tdo, dmi_tdo}), 64'd0);
  endtask

  initial begin
    logic [1:0] rop;
    repeat (3) @(negedge tck);
    check_reset_outputs("reset");
    @(posedge tck); #1;
    trst = 1'b0;

    // DTMCS readout
    dtmcs_scan(32'h0);

    // Write with ready held low, then readback
    dmi_scan(7'h10, 32'h1, 2'd2, 1'b1);
    dm_handshake(3);
    dm_respond(32'h0, 2'd0, 1);
    dmi_scan(7'h10, 32'h0, 2'd0, 1'b1);

    // Read, readback of response data
    dmi_scan(7'h04, 32'h0, 2'd1, 1'b1);
    dm_handshake(0);
    dm_respond(32'hDEAD_BEEF, 2'd0, 2);
    dmi_scan(7'h04, 32'h0, 2'd0, 1'b1);

    // Busy: capture during outstanding read, ignored write, sticky busy
    dmi_scan(7'h05, 32'h0, 2'd1, 1'b1);
    dm_handshake(1);
    dmi_scan(7'h06, 32'h55, 2'd2, 1'b1);
    check_no_req(3);
    dm_respond(32'h1234, 2'd0, 0);
    dmi_scan(7'h06, 32'h0, 2'd0, 1'b1);
    dtmcs_scan(32'h0001_0000);
    dmi_scan(7'h07, 32'h0, 2'd0, 1'b1);
    dtmcs_scan(32'h0);

    // Busy via update without capture
    dmi_scan(7'h08, 32'h0, 2'd1, 1'b0);
    dm_handshake(0);
    dmi_scan(7'h09, 32'hAA, 2'd2, 1'b0);
    dm_respond(32'h77, 2'd0, 0);
    dtmcs_scan(32'h0001_0000);

    // Failure: error 2 blocks updates until dmireset
    dmi_scan(7'h0A, 32'h0, 2'd1, 1'b1);
    dm_handshake(0);
    dm_respond(32'h0, 2'd2, 0);
    dmi_scan(7'h0B, 32'h99, 2'd2, 1'b1);
    check_no_req(3);
    dtmcs_scan(32'h0);
    dtmcs_scan(32'h0001_0000);
    dmi_scan(7'h0C, 32'h42, 2'd2, 1'b1);
    dm_handshake(0);
    dm_respond(32'h0, 2'd0, 0);

    // Hardreset with outstanding write, then a stale response
    dmi_scan(7'h0D, 32'hCAFE, 2'd2, 1'b1);
    dtmcs_scan(32'h0002_0000);
    @(posedge tck); #1;
    resp_valid = 1'b1; resp_data = 32'hBAD0_BAD0; resp_op = 2'd0;
    @(negedge tck);
    check("stale_resp_ready", 64'(resp_ready), 64'd1);
    @(posedge tck); #1;
    resp_valid = 1'b0;
    dmi_scan(7'h0D, 32'h0, 2'd0, 1'b1);

    // Asynchronous reset during Read
    dmi_scan(7'h0E, 32'h0, 2'd1, 1'b1);
    @(posedge tck); #1;
    trst = 1'b1;
    #2;
    check_reset_outputs("trst_mid_read");
    @(posedge tck); #1;
    trst = 1'b0;
    model_reset();
    check_no_req(2);

    // Synchronous clear during Write
    dmi_scan(7'h0F, 32'h1, 2'd2, 1'b1);
    @(posedge tck); #1;
    dmi_clear = 1'b1;
    @(posedge tck); #1;
    dmi_clear = 1'b0;
    model_reset();
    @(negedge tck);
    check_reset_outputs("clear");
    dtmcs_scan(32'h0);

    // Randomized transactions
    for (int it = 0; it < 16; it++) begin
      dmi_scan(7'($urandom), $urandom, 2'($urandom_range(0, 3)), 1'b1);
      if (m_pending) begin
        if ($urandom_range(0, 3) == 0) dmi_scan(7'($urandom), $urandom, 2'd0, 1'b1);
        dm_handshake($urandom_range(0, 2));
        if ($urandom_range(0, 3) == 0) dmi_scan(7'($urandom), $urandom, 2'd2, 1'b1);
        rop = ($urandom_range(0, 4) == 0) ? 2'd2 : 2'd0;
        dm_respond($urandom, rop, $urandom_range(0, 2));
      end
      dmi_scan(7'($urandom), 32'h0, 2'd0, 1'b1);
      dtmcs_scan((m_err != 2'd0) ? 32'h0001_0000 : 32'h0);
    end

    repeat (2) @(negedge tck);
    check("exp_req_left", 64'(exp_req_q.size()), 64'd0);
    check("exp_scan_left", 64'(exp_scan_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
